// File: rtl/pxs_str_join_aligned_if.sv
// Pixel-stream join bus: timing group and colour in, packed VGA word out.
// AlignErr exists only when PXS_JOIN_ALIGN_CHECK_EN is defined.
interface pxs_str_join_aligned_if #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 1
);
    localparam int STR_W = 3 + 2*COORD_W + 3*COLOR_W;

    // Handshake: no valid/ready pair. PxEn qualifies every input on a rising
    // edge; the sink must accept each word, and VGAStr only changes after an
    // enabled edge (or reset).
    logic               PxEn;
    logic               HSync;
    logic               VSync;
    logic               ActiveVideo;
    logic [COORD_W-1:0] XCoord;
    logic [COORD_W-1:0] YCoord;
    logic [COLOR_W-1:0] Red;
    logic [COLOR_W-1:0] Green;
    logic [COLOR_W-1:0] Blue;
    logic [STR_W-1:0]   VGAStr;
`ifdef PXS_JOIN_ALIGN_CHECK_EN
    logic               AlignErr;

    modport master (
        output PxEn, HSync, VSync, ActiveVideo, XCoord, YCoord, Red, Green, Blue,
        input  VGAStr, AlignErr
    );
    modport slave (
        input  PxEn, HSync, VSync, ActiveVideo, XCoord, YCoord, Red, Green, Blue,
        output VGAStr, AlignErr
    );
`else
    modport master (
        output PxEn, HSync, VSync, ActiveVideo, XCoord, YCoord, Red, Green, Blue,
        input  VGAStr
    );
    modport slave (
        input  PxEn, HSync, VSync, ActiveVideo, XCoord, YCoord, Red, Green, Blue,
        output VGAStr
    );
`endif
endinterface

// File: rtl/pxs_str_join_aligned.sv
// Registered pixel-stream join: delays timing by DELAY enabled cycles to meet
// pipelined colour. Optional alignment checker: define PXS_JOIN_ALIGN_CHECK_EN.
module pxs_str_join_aligned #(
    parameter int COORD_W  = 10,
    parameter int COLOR_W  = 1,
    parameter int DELAY    = 0,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    pxs_str_join_aligned_if.slave  bus
);
    localparam int STR_W = 3 + 2*COORD_W + 3*COLOR_W;
    localparam int TW    = 3 + 2*COORD_W;
    localparam int CW    = 3*COLOR_W;

    // Idle timing word: syncs inactive, blanked, coordinates zero.
    localparam logic [TW-1:0] TIM_RST = {{(2*COORD_W+1){1'b0}}, ~SYNC_POL, ~SYNC_POL};

    logic [TW-1:0] tim_in;
    logic [TW-1:0] tim_dly;
    logic [CW-1:0] rgb_in;
    logic [CW-1:0] rgb_blk;
    logic [TW-1:0] tim_q;
    logic [CW-1:0] rgb_q;

    assign tim_in = {bus.YCoord, bus.XCoord, bus.ActiveVideo, bus.VSync, bus.HSync};
    assign rgb_in = {bus.Blue, bus.Green, bus.Red};

    generate
        if (DELAY < 0 || DELAY > 15) begin : g_bad_delay
            $error("pxs_str_join_aligned: DELAY must be within 0..15");
        end

        if (DELAY == 0) begin : g_no_delay
            assign tim_dly = tim_in;
        end else begin : g_delay
            logic [TW-1:0] sr [DELAY];

            // Reset fills every stage so no pre-reset word can surface later.
            always_ff @(posedge Clk) begin
                if (!Rst_n) begin
                    for (int i = 0; i < DELAY; i++) sr[i] <= TIM_RST;
                end else if (bus.PxEn) begin
                    sr[0] <= tim_in;
                    for (int i = 1; i < DELAY; i++) sr[i] <= sr[i-1];
                end
            end

            assign tim_dly = sr[DELAY-1];
        end
    endgenerate

    // Colour is blanked by the Active flag that travels with it to the output.
    assign rgb_blk = tim_dly[2] ? rgb_in : '0;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            tim_q <= TIM_RST;
            rgb_q <= '0;
        end else if (bus.PxEn) begin
            tim_q <= tim_dly;
            rgb_q <= rgb_blk;
        end
    end

    assign bus.VGAStr = {rgb_q, tim_q};

`ifdef PXS_JOIN_ALIGN_CHECK_EN
    logic               cur_act;
    logic               prev_act;
    logic [COORD_W-1:0] cur_xc;
    logic [COORD_W-1:0] prev_xc;
    logic               bad_word;
    logic               hit_q;
    logic               align_err_q;

    // Compare the word entering the output register with the one it replaces.
    assign cur_act  = tim_dly[2];
    assign cur_xc   = tim_dly[3 +: COORD_W];
    assign prev_act = tim_q[2];
    assign prev_xc  = tim_q[3 +: COORD_W];

    always_comb begin
        bad_word = 1'b0;
        if (cur_act && prev_act && (cur_xc != prev_xc + COORD_W'(1)))
            bad_word = 1'b1;
        if (cur_act && !prev_act && (cur_xc != '0))
            bad_word = 1'b1;
    end

    // hit_q marks the edge the bad word is output; the flag follows a cycle later.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            hit_q       <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            hit_q       <= bus.PxEn & bad_word;
            align_err_q <= align_err_q | hit_q;
        end
    end

    assign bus.AlignErr = align_err_q;
`endif

endmodule

// File: tb/tb_pxs_str_join_aligned.sv
// Directed bench for pxs_str_join_aligned: three configurations side by side
// (DELAY=0/COLOR_W=1, DELAY=3/COLOR_W=8, DELAY=2/COLOR_W=8/SYNC_POL=1).
module tb_pxs_str_join_aligned;

    logic Clk = 1'b0;
    logic Rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    pxs_str_join_aligned_if #(.COORD_W(10), .COLOR_W(1)) i0 ();
    pxs_str_join_aligned_if #(.COORD_W(10), .COLOR_W(8)) i3 ();
    pxs_str_join_aligned_if #(.COORD_W(10), .COLOR_W(8)) i2 ();

    pxs_str_join_aligned #(.COORD_W(10), .COLOR_W(1), .DELAY(0), .SYNC_POL(1'b0))
        d0 (.Clk(Clk), .Rst_n(Rst_n), .bus(i0));
    pxs_str_join_aligned #(.COORD_W(10), .COLOR_W(8), .DELAY(3), .SYNC_POL(1'b0))
        d3 (.Clk(Clk), .Rst_n(Rst_n), .bus(i3));
    pxs_str_join_aligned #(.COORD_W(10), .COLOR_W(8), .DELAY(2), .SYNC_POL(1'b1))
        d2 (.Clk(Clk), .Rst_n(Rst_n), .bus(i2));

    function automatic logic [25:0] e0(input logic hs, vs, act, input logic [9:0] x, y,
                                       input logic r, g, b);
        return {b, g, r, y, x, act, vs, hs};
    endfunction

    function automatic logic [46:0] e8(input logic hs, vs, act, input logic [9:0] x, y,
                                       input logic [7:0] r, g, b);
        return {b, g, r, y, x, act, vs, hs};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drv0(input logic en, hs, vs, act, input logic [9:0] x, y, input logic r, g, b);
        i0.PxEn = en; i0.HSync = hs; i0.VSync = vs; i0.ActiveVideo = act;
        i0.XCoord = x; i0.YCoord = y; i0.Red = r; i0.Green = g; i0.Blue = b;
    endtask

    task automatic drv3(input logic en, hs, vs, act, input logic [9:0] x, y, input logic [7:0] r, g, b);
        i3.PxEn = en; i3.HSync = hs; i3.VSync = vs; i3.ActiveVideo = act;
        i3.XCoord = x; i3.YCoord = y; i3.Red = r; i3.Green = g; i3.Blue = b;
    endtask

    task automatic drv2(input logic en, hs, vs, act, input logic [9:0] x, y, input logic [7:0] r, g, b);
        i2.PxEn = en; i2.HSync = hs; i2.VSync = vs; i2.ActiveVideo = act;
        i2.XCoord = x; i2.YCoord = y; i2.Red = r; i2.Green = g; i2.Blue = b;
    endtask

    task automatic chk0(input string tag, input logic [25:0] exp);
        total++;
        assert (i0.VGAStr === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, i0.VGAStr, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [46:0] exp);
        total++;
        assert (i3.VGAStr === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, i3.VGAStr, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [46:0] exp);
        total++;
        assert (i2.VGAStr === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, i2.VGAStr, exp);
        end
    endtask

`ifdef PXS_JOIN_ALIGN_CHECK_EN
    task automatic chkae(input string tag, input logic exp);
        total++;
        assert (i0.AlignErr === exp) else begin
            bad++;
            $error("FAIL %s: got=%b exp=%b", tag, i0.AlignErr, exp);
        end
    endtask
`endif

    initial begin
        // Reset held 3 cycles with random inputs, PxEn included
        Rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drv0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drv3(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 10'($urandom_range(0, 1023)), 10'd1,
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            drv2(1'b1, 1'b1, 1'b1, 1'b1, 10'($urandom_range(0, 1023)), 10'd2,
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            tick();
            chk0("rst_d0", 26'h3);
            chk3("rst_d3", 47'h3);
            chk2("rst_d2", 47'h0);
        end
        Rst_n = 1'b1;
        drv3(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00);
        drv2(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00);

        // DELAY=0: one enabled cycle of latency
        drv0(1'b1, 1'b0, 1'b0, 1'b1, 10'd5, 10'd7, 1'b1, 1'b1, 1'b1);
        tick(); chk0("d0_px", e0(1'b0, 1'b0, 1'b1, 10'd5, 10'd7, 1'b1, 1'b1, 1'b1));
        drv0(1'b1, 1'b1, 1'b0, 1'b0, 10'd6, 10'd7, 1'b1, 1'b1, 1'b1);
        tick(); chk0("d0_blank", e0(1'b1, 1'b0, 1'b0, 10'd6, 10'd7, 1'b0, 1'b0, 1'b0));
        drv0(1'b0, 1'b0, 1'b1, 1'b1, 10'd9, 10'd9, 1'b1, 1'b1, 1'b1);
        tick(); chk0("d0_hold", e0(1'b1, 1'b0, 1'b0, 10'd6, 10'd7, 1'b0, 1'b0, 1'b0));
        drv0(1'b1, 1'b0, 1'b1, 1'b1, 10'd1023, 10'd0, 1'b1, 1'b0, 1'b1);
        tick(); chk0("d0_max", e0(1'b0, 1'b1, 1'b1, 10'd1023, 10'd0, 1'b1, 1'b0, 1'b1));
        drv0(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);

        // DELAY=3: timing X=20 meets colour presented three enabled cycles later
        drv3(1'b1, 1'b0, 1'b0, 1'b1, 10'd20, 10'd3, 8'h11, 8'h11, 8'h11);
        tick(); chk3("d3_fill0", 47'h3);
        drv3(1'b1, 1'b0, 1'b0, 1'b1, 10'd21, 10'd3, 8'h22, 8'h22, 8'h22);
        tick(); chk3("d3_fill1", 47'h3);
        drv3(1'b1, 1'b0, 1'b0, 1'b1, 10'd22, 10'd3, 8'h33, 8'h33, 8'h33);
        tick(); chk3("d3_fill2", 47'h3);
        drv3(1'b1, 1'b0, 1'b0, 1'b1, 10'd23, 10'd3, 8'hA5, 8'h5A, 8'hC3);
        tick(); chk3("d3_align", e8(1'b0, 1'b0, 1'b1, 10'd20, 10'd3, 8'hA5, 8'h5A, 8'hC3));
        drv3(1'b1, 1'b1, 1'b0, 1'b0, 10'd30, 10'd4, 8'h01, 8'h02, 8'h03);
        tick(); chk3("d3_x21", e8(1'b0, 1'b0, 1'b1, 10'd21, 10'd3, 8'h01, 8'h02, 8'h03));
        drv3(1'b1, 1'b1, 1'b0, 1'b0, 10'd31, 10'd4, 8'h04, 8'h05, 8'h06);
        tick(); chk3("d3_x22", e8(1'b0, 1'b0, 1'b1, 10'd22, 10'd3, 8'h04, 8'h05, 8'h06));
        drv3(1'b1, 1'b1, 1'b0, 1'b0, 10'd32, 10'd4, 8'h07, 8'h08, 8'h09);
        tick(); chk3("d3_x23", e8(1'b0, 1'b0, 1'b1, 10'd23, 10'd3, 8'h07, 8'h08, 8'h09));
        drv3(1'b1, 1'b0, 1'b0, 1'b1, 10'd50, 10'd5, 8'hFF, 8'hFF, 8'hFF);
        tick(); chk3("d3_blank30", e8(1'b1, 1'b0, 1'b0, 10'd30, 10'd4, 8'h00, 8'h00, 8'h00));
        drv3(1'b1, 1'b0, 1'b0, 1'b1, 10'd51, 10'd5, 8'hFF, 8'hFF, 8'hFF);
        tick(); chk3("d3_blank31", e8(1'b1, 1'b0, 1'b0, 10'd31, 10'd4, 8'h00, 8'h00, 8'h00));
        drv3(1'b1, 1'b0, 1'b0, 1'b1, 10'd52, 10'd5, 8'hFF, 8'hFF, 8'hFF);
        tick(); chk3("d3_blank32", e8(1'b1, 1'b0, 1'b0, 10'd32, 10'd4, 8'h00, 8'h00, 8'h00));
        drv3(1'b0, 1'b0, 1'b1, 1'b1, 10'd99, 10'd9, 8'h12, 8'h34, 8'h56);
        tick(); chk3("d3_hold", e8(1'b1, 1'b0, 1'b0, 10'd32, 10'd4, 8'h00, 8'h00, 8'h00));

        // DELAY=2, SYNC_POL=1, PxEn alternating; junk on disabled cycles
        for (int j = 0; j < 5; j++) begin
            logic [46:0] exp;
            drv2(1'b1, 1'b1, 1'b0, 1'b1, 10'(100 + j), 10'd9,
                 8'(8'h10 + j), 8'(8'h20 + j), 8'(8'h30 + j));
            tick();
            exp = (j < 2) ? 47'h0
                          : e8(1'b1, 1'b0, 1'b1, 10'(100 + j - 2), 10'd9,
                               8'(8'h10 + j), 8'(8'h20 + j), 8'(8'h30 + j));
            chk2("d2_en", exp);
            drv2(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            tick();
            chk2("d2_hold", exp);
        end
        drv2(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00);

        // Mid-frame reset while d3 holds active words X=50..52 in its shift stages
        Rst_n = 1'b0;
        drv3(1'b1, 1'b0, 1'b0, 1'b1, 10'd70, 10'd6, 8'h99, 8'h99, 8'h99);
        tick();
        chk3("d3_rstmid", 47'h3);
        chk0("d0_rstmid", 26'h3);
        Rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv3(1'b1, 1'b0, 1'b0, 1'b1, 10'(60 + k), 10'd6, 8'h77, 8'h77, 8'h77);
            tick();
            chk3("d3_refill", (k < 3) ? 47'h3
                                      : e8(1'b0, 1'b0, 1'b1, 10'd60, 10'd6, 8'h77, 8'h77, 8'h77));
        end
        drv3(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00);

`ifdef PXS_JOIN_ALIGN_CHECK_EN
        chkae("ae_rst", 1'b0);
        for (int x = 0; x < 640; x++) begin
            drv0(1'b1, 1'b0, 1'b0, 1'b1, 10'(x), 10'd1, 1'b1, 1'b1, 1'b1);
            tick();
        end
        drv0(1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd2, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chkae("ae_clean_line", 1'b0);
        drv0(1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 10'd2, 1'b1, 1'b0, 1'b0); tick();
        drv0(1'b1, 1'b0, 1'b0, 1'b1, 10'd1, 10'd2, 1'b1, 1'b0, 1'b0); tick();
        drv0(1'b1, 1'b0, 1'b0, 1'b1, 10'd2, 10'd2, 1'b1, 1'b0, 1'b0); tick();
        chkae("ae_before_gap", 1'b0);
        drv0(1'b1, 1'b0, 1'b0, 1'b1, 10'd4, 10'd2, 1'b1, 1'b0, 1'b0); tick();
        chkae("ae_same_cycle", 1'b0);
        drv0(1'b0, 1'b0, 1'b0, 1'b1, 10'd5, 10'd2, 1'b1, 1'b0, 1'b0); tick();
        chkae("ae_set", 1'b1);
        drv0(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd2, 1'b0, 1'b0, 1'b0); tick(); tick();
        chkae("ae_sticky", 1'b1);
        Rst_n = 1'b0; tick();
        Rst_n = 1'b1;
        chkae("ae_cleared", 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pxs_str_join_aligned.md
Name: pxs_str_join_aligned

Overview:
- Parametrised, registered successor of the combinational pixel-stream join.
- Packs timing fields (HSync, VSync, ActiveVideo, XCoord, YCoord) and a multi-bit RGB triple into one VGA stream word.
- Delays the timing group by a configurable number of pixel-enabled cycles, so it realigns with colour that left a pipelined filter.
- Sits at the output of every processing chain, just before the stream sink / VGA driver.

Parameters:
- COORD_W, 10, width of XCoord and YCoord.
- COLOR_W, 1, width of each colour channel.
- DELAY, 0, extra pixel-enabled cycles applied to the timing group (legal range 0..15).
- SYNC_POL, 0, active level of HSync/VSync; the inactive level is ~SYNC_POL.
- STR_W, 3+2*COORD_W+3*COLOR_W, stream width (26 at defaults). Derived; must not be overridden.

Ports:
- Clk  in  1  pixel clock
- Rst_n  in  1  synchronous reset, active-low
- PxEn  in  1  pixel enable; the pipeline advances only when high
- HSync  in  1  horizontal sync
- VSync  in  1  vertical sync
- ActiveVideo  in  1  active-area flag
- XCoord  in  COORD_W  scan X
- YCoord  in  COORD_W  scan Y
- Red  in  COLOR_W  red
- Green  in  COLOR_W  green
- Blue  in  COLOR_W  blue
- VGAStr  out  STR_W  packed output stream
- AlignErr  out  1  sticky alignment error (present only with the optional feature, see below)

Behaviour:
- Single clock domain, Clk. Reset is synchronous and active-low (Rst_n sampled on the rising edge of Clk).
- Stream layout, LSB first:
  - [0] HS, [1] VS, [2] Active
  - XC at [3 +: COORD_W], YC at [3+COORD_W +: COORD_W]
  - R, G, B following, COLOR_W each, B in the MSBs
  - Defaults give exactly 26 bits.
- Timing path: shift register of DELAY stages, then one output register. Timing latency is DELAY+1 enabled cycles. DELAY=0 means no shift stages.
- Colour path: one output register only. Colour latency is 1 enabled cycle.
- All registers load only when PxEn=1. When PxEn=0, every register, including VGAStr, holds.
- Blanking: if the delayed Active is 0, the registered R, G and B fields are forced to 0 regardless of the inputs.
- Reset, with Rst_n=0 at a rising edge:
  - VGAStr HS and VS = ~SYNC_POL; Active, XC, YC, R, G, B = 0.
  - Every shift stage is loaded with the same values.
  - Reset overrides PxEn.
- Reset mid-frame: the output shows blanked, inactive-sync words for DELAY+1 enabled cycles after release while the pipeline refills. No stale pre-reset timing word may ever reach VGAStr.
- PxEn toggling every cycle: latency is counted in enabled cycles, never in Clk cycles.
- No backpressure and no handshake beyond PxEn. The block never drops or duplicates a pixel.
- DELAY outside 0..15: elaboration error (generate-time check).

Optional Feature:
- Macro: PXS_JOIN_ALIGN_CHECK_EN.
- When defined, AlignErr is present and a checker watches the delayed timing group on enabled cycles. It sets AlignErr (sticky) when any of these holds:
  - Delayed Active stays 1 on consecutive enabled cycles and delayed XC does not equal previous XC+1 (mod 2^COORD_W).
  - Delayed Active rises and delayed XC is not 0.
- AlignErr resets to 0 only via Rst_n. It is registered, one cycle after the offending output word.
- When not defined: the AlignErr port and all checker logic are absent, and VGAStr behaviour is identical.

Test Plan:
- Reset hold, defaults: Rst_n=0 for 3 cycles with random inputs -> VGAStr=26'b0...011 (HS=VS=1 since SYNC_POL=0). Other fields 0.
- DELAY=0, PxEn=1, input X=5, Y=7, Active=1, R=G=B=1 at cycle n -> at cycle n+1 VGAStr XC=5, YC=7, RGB=3'b111.
- DELAY=3, COLOR_W=8: timing X=20 at cycle n and colour 8'hA5 presented at cycle n+3 -> both appear together in VGAStr at cycle n+4.
- Blanking: Active=0 with R=G=B=8'hFF -> output RGB fields all 0. Sync/coord fields still pass with the correct latency.
- PxEn pattern 1,0,1,0 with DELAY=2 -> VGAStr changes only after enabled cycles. The word for pixel k appears after its 3rd enabled cycle.
- With PXS_JOIN_ALIGN_CHECK_EN: active X sequence 0,1,2,4 -> AlignErr=1 one cycle after X=4 is output, and stays 1 until Rst_n=0. A clean 640-pixel line keeps AlignErr=0.
